ram_io_responder: RTL and testbench
===================================

// Module: ram_io_responder
// PURPOSE
//  Memory-side end of the CPU byte bus: answers the CPU's mem_a/mem_dout/mem_wr requests and
//  returns read data on mem_din one cycle later. Decodes a byte RAM (128KB) and the IO window
//  (mem_a[17:16]==2'b11): UART TX through a FIFO, UART RX byte read, cycle counter, program stop.
//  Sits between the cpu top and the UART/testbench; drives the CPU's io_buffer_full.
// PARAMETERS
//  RAM_ADDR_W    17  RAM byte-address width (2^17 bytes)
//  TX_DEPTH      8   TX FIFO entries, power of two, >= 4
//  FULL_MARGIN   2   io_buffer_full asserts when free entries <= FULL_MARGIN
// PORTS
//  clk_in          in   1   clock
//  rst_in          in   1   synchronous active-high reset
//  rdy_in          in   1   global ready; low freezes all state except RAM contents already written
//  mem_a           in   32  CPU address; bits [31:18] ignored
//  mem_wr          in   1   1 = write, 0 = read
//  mem_wdata       in   8   CPU write byte (CPU's mem_dout)
//  mem_rdata       out  8   read byte to CPU (CPU's mem_din), registered
//  io_buffer_full  out  1   TX FIFO nearly full
//  tx_data         out  8   TX FIFO head byte
//  tx_valid        out  1   TX FIFO non-empty
//  tx_ready        in   1   UART accepts tx_data this cycle
//  rx_data         in   8   UART received byte
//  rx_valid        in   1   rx_data holds an unread byte
//  rx_pop          out  1   1-cycle pulse: rx_data consumed
//  prog_done       out  1   sticky: program wrote 0x30004
//  tx_overflow     out  1   sticky: a TX byte was dropped on full FIFO
// BEHAVIOUR
//  - Reset: mem_rdata=0, FIFO empty (tx_valid=0), io_buffer_full=0, rx_pop=0, prog_done=0,
//    tx_overflow=0, cycle counter=0, snapshot=0. RAM contents not reset.
//  - rdy_in=0: no RAM write, no FIFO push/pop, no rx_pop, counter holds, mem_rdata holds.
//  - Cycle counter: 32-bit, +1 every rdy_in-high cycle after reset, wraps 0xFFFFFFFF->0.
//  - RAM (mem_a[17:16]!=2'b11): read -> mem_rdata = ram[mem_a[RAM_ADDR_W-1:0]] at next edge
//    (1-cycle latency, new address every cycle); write -> byte stored at the edge, no wait.
//    Read-after-write same address next cycle returns the new byte.
//  - IO read 0x30000: rx_valid=1 -> mem_rdata=rx_data, rx_pop=1 for one cycle; else mem_rdata=0.
//  - IO read 0x30004..0x30007: byte (addr-0x30004) of counter value, little-endian (see CONFIG).
//  - IO read of any other IO address -> 0x00. IO write to other addresses ignored.
//  - IO write 0x30000: byte!=0 -> push TX FIFO; byte==0 ignored.
//  - IO write 0x30004: push 0x00 into FIFO (zero filter bypassed), set prog_done. While
//    prog_done=1 all further IO writes are ignored; RAM still serviced.
//  - Push when full: accepted if a pop occurs the same cycle, else byte dropped, tx_overflow=1.
//  - Pop when tx_valid && tx_ready. Simultaneous push+pop: count unchanged, order preserved.
//  - Pointers wrap modulo TX_DEPTH; count has log2(TX_DEPTH)+1 bits.
//  - io_buffer_full registered: 1 when (TX_DEPTH - count_next) <= FULL_MARGIN.
// CONFIGURATION
//  CYCLE_SNAPSHOT_EN defined: a read of 0x30004 returns counter[7:0] and latches the full
//    counter into a snapshot; reads of 0x30005..7 return snapshot bytes 1..3 (coherent word).
//  Not defined: every byte read of 0x30004..7 returns the corresponding byte of the live counter.
// TESTING
//  1. Write 0xA5 to 0x00010, read 0x00010 next cycle -> mem_rdata=0xA5 one cycle after the read.
//  2. rx_valid=1, rx_data=0x41, read 0x30000 -> mem_rdata=0x41, rx_pop=1 single cycle;
//     rx_valid=0 read -> 0x00, rx_pop=0.
//  3. TX_DEPTH=8, tx_ready=0, write 'a'..'h' to 0x30000 -> io_buffer_full=1 after 6th push,
//     9th write dropped, tx_overflow=1; tx_ready=1 -> bytes drain 'a'..'h' in order.
//  4. Write 0x00 to 0x30000 -> no push; write 0x00 to 0x30004 -> 0x00 in FIFO, prog_done=1,
//     later write 0x42 to 0x30000 ignored.
//  5. Counter=0x000000FF at 0x30004 read, reads of 0x30005 next -> snapshot on: 0x00;
//     snapshot off: live byte 1 (0x01 once counter passes 0x100).
//  6. rdy_in=0 for 5 cycles mid-write stream -> counter, FIFO, mem_rdata unchanged; rst_in=1
//     with full FIFO -> all outputs to reset values next edge.

Source files
------------

// File: rtl/ram_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : ram_io_responder
// Description : Memory-side end of the CPU byte bus. It services CPU read and
//               write requests to a byte RAM and to an IO window at
//               0x30000-0x3FFFF. Read data is returned one cycle later.
//               The IO window provides UART TX through a FIFO, a UART RX byte,
//               a 32-bit cycle counter and a program-stop register.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_in          in   1   clock
//   rst_in          in   1   synchronous active-high reset
//   rdy_in          in   1   global ready; low freezes all state
//   mem_a           in  32   CPU byte address (bits [31:18] ignored)
//   mem_wr          in   1   1 = write, 0 = read
//   mem_wdata       in   8   CPU write byte
//   mem_rdata       out  8   read byte, one cycle after the request
//   io_buffer_full  out  1   TX FIFO nearly full (registered)
//   tx_data         out  8   TX FIFO head byte
//   tx_valid        out  1   TX FIFO non-empty
//   tx_ready        in   1   UART accepts tx_data this cycle
//   rx_data         in   8   UART received byte
//   rx_valid        in   1   rx_data holds an unread byte
//   rx_pop          out  1   rx_data consumed this cycle
//   prog_done       out  1   sticky: program wrote 0x30004
//   tx_overflow     out  1   sticky: a TX byte was dropped on a full FIFO
// Build option
//   CYCLE_SNAPSHOT_EN : reading 0x30004 latches the whole counter so that
//                       0x30005..0x30007 return a coherent word. Without it,
//                       every byte comes from the live counter.
// ============================================================================
module ram_io_responder #(
  parameter int RAM_ADDR_W  = 17,
  parameter int TX_DEPTH    = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_pop,
  output logic        prog_done,
  output logic        tx_overflow
);

  localparam int c_ptr_w = $clog2(TX_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth  = c_cnt_w'(TX_DEPTH);
  localparam logic [31:0]        c_margin = 32'(FULL_MARGIN);

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [17:0]           w_addr;
  logic [RAM_ADDR_W-1:0] w_ram_addr;
  logic                  w_is_io;
  logic                  w_io_rx;
  logic                  w_io_cnt;
  logic                  w_io_stop;
  logic                  w_unused_addr_hi;

  assign w_addr           = mem_a[17:0];
  assign w_ram_addr       = mem_a[RAM_ADDR_W-1:0];
  assign w_is_io          = (w_addr[17:16] == 2'b11);
  assign w_io_rx          = (w_addr == 18'h30000);
  assign w_io_cnt         = (w_addr[17:2] == 16'hC001);  // 0x30004..0x30007
  assign w_io_stop        = (w_addr == 18'h30004);
  assign w_unused_addr_hi = &{1'b0, mem_a[31:18]};

  // --------------------------------------------------------------------------
  // Byte RAM. Contents are never reset. The read port is registered so the
  // array maps onto block RAM; a write followed next cycle by a read of the
  // same address sees the new byte because the write lands first.
  // --------------------------------------------------------------------------
  logic [7:0] ram_mem [0:(1<<RAM_ADDR_W)-1];
  logic [7:0] ram_rdata_q;
  logic       w_ram_we;
  logic       w_ram_re;

  assign w_ram_we = rdy_in &&  mem_wr && !w_is_io;
  assign w_ram_re = rdy_in && !mem_wr && !w_is_io;

  always_ff @(posedge clk_in) begin
    if (w_ram_we) begin
      ram_mem[w_ram_addr] <= mem_wdata;
    end
    if (w_ram_re) begin
      ram_rdata_q <= ram_mem[w_ram_addr];
    end
  end

  // --------------------------------------------------------------------------
  // Cycle counter
  // --------------------------------------------------------------------------
  logic [31:0] counter_q, counter_d;
  logic [7:0]  w_cnt_byte;

  assign counter_d = rdy_in ? counter_q + 32'd1 : counter_q;

`ifdef CYCLE_SNAPSHOT_EN
  // Byte 0 comes from the live counter and captures the whole word at the
  // same time, so a 4-byte read sequence never sees a carry ripple mid-word.
  logic [31:0] snapshot_q, snapshot_d;

  always_comb begin
    snapshot_d = snapshot_q;
    if (rdy_in && !mem_wr && w_io_cnt && (w_addr[1:0] == 2'b00)) begin
      snapshot_d = counter_q;
    end
  end

  always_comb begin
    w_cnt_byte = counter_q[7:0];
    case (w_addr[1:0])
      2'b01:   w_cnt_byte = snapshot_q[15:8];
      2'b10:   w_cnt_byte = snapshot_q[23:16];
      2'b11:   w_cnt_byte = snapshot_q[31:24];
      default: w_cnt_byte = counter_q[7:0];
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      snapshot_q <= 32'd0;
    end else begin
      snapshot_q <= snapshot_d;
    end
  end
`else
  always_comb begin
    w_cnt_byte = counter_q[7:0];
    case (w_addr[1:0])
      2'b01:   w_cnt_byte = counter_q[15:8];
      2'b10:   w_cnt_byte = counter_q[23:16];
      2'b11:   w_cnt_byte = counter_q[31:24];
      default: w_cnt_byte = counter_q[7:0];
    endcase
  end
`endif

  // --------------------------------------------------------------------------
  // Request handling: read-data source, RX pop, TX push requests, stop flag.
  // mem_rdata is a select between two registers (RAM read port or IO read
  // byte), so it stays a registered value with no request-path logic.
  // --------------------------------------------------------------------------
  logic       rd_sel_ram_q, rd_sel_ram_d;
  logic [7:0] io_rdata_q, io_rdata_d;
  logic       prog_done_q, prog_done_d;
  logic       w_rx_pop;
  logic       w_push_req;
  logic [7:0] w_push_byte;

  always_comb begin
    rd_sel_ram_d = rd_sel_ram_q;
    io_rdata_d   = io_rdata_q;
    prog_done_d  = prog_done_q;
    w_rx_pop     = 1'b0;
    w_push_req   = 1'b0;
    w_push_byte  = mem_wdata;
    if (rdy_in) begin
      if (!mem_wr) begin
        if (!w_is_io) begin
          rd_sel_ram_d = 1'b1;
        end else begin
          rd_sel_ram_d = 1'b0;
          io_rdata_d   = 8'h00;
          if (w_io_rx) begin
            if (rx_valid) begin
              io_rdata_d = rx_data;
              w_rx_pop   = 1'b1;
            end
          end else if (w_io_cnt) begin
            io_rdata_d = w_cnt_byte;
          end
        end
      end else if (w_is_io && !prog_done_q) begin
        // Once the program has stopped, the IO side goes quiet for writes.
        if (w_io_rx) begin
          // A zero byte to the TX port is a no-op.
          w_push_req = (mem_wdata != 8'h00);
        end else if (w_io_stop) begin
          // The stop write sends a 0x00 marker down the UART.
          w_push_req  = 1'b1;
          w_push_byte = 8'h00;
          prog_done_d = 1'b1;
        end
      end
    end
  end

  // The pop is combinational so the UART drops the byte in the same cycle
  // it is sampled; a back-to-back read can never see the same byte twice.
  assign rx_pop = w_rx_pop && !rst_in;

  // --------------------------------------------------------------------------
  // TX FIFO
  // --------------------------------------------------------------------------
  logic [7:0]         tx_mem [0:TX_DEPTH-1];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic               full_q, full_d;
  logic               overflow_q, overflow_d;
  logic               w_pop;
  logic               w_push_ok;
  logic [c_cnt_w-1:0] w_free_next;

  always_comb begin
    w_pop       = rdy_in && (count_q != '0) && tx_ready;
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    w_push_ok   = w_push_req && ((count_q != c_depth) || w_pop);
    overflow_d  = overflow_q || (w_push_req && !w_push_ok);
    wr_ptr_d    = w_push_ok ? wr_ptr_q + c_ptr_w'(1) : wr_ptr_q;
    rd_ptr_d    = w_pop     ? rd_ptr_q + c_ptr_w'(1) : rd_ptr_q;
    count_d     = count_q + c_cnt_w'(w_push_ok) - c_cnt_w'(w_pop);
    w_free_next = c_depth - count_d;
    full_d      = (32'(w_free_next) <= c_margin);
  end

  always_ff @(posedge clk_in) begin
    if (w_push_ok) begin
      tx_mem[wr_ptr_q] <= w_push_byte;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      counter_q    <= 32'd0;
      rd_sel_ram_q <= 1'b0;
      io_rdata_q   <= 8'h00;
      prog_done_q  <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      counter_q    <= counter_d;
      rd_sel_ram_q <= rd_sel_ram_d;
      io_rdata_q   <= io_rdata_d;
      prog_done_q  <= prog_done_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
    end
  end

  assign mem_rdata      = rd_sel_ram_q ? ram_rdata_q : io_rdata_q;
  assign io_buffer_full = full_q;
  assign tx_data        = tx_mem[rd_ptr_q];
  assign tx_valid       = (count_q != '0);
  assign prog_done      = prog_done_q;
  assign tx_overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_io_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_io_responder
// Description : Directed self-checking bench for ram_io_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_pop;
  logic        prog_done;
  logic        tx_overflow;

  int checks = 0;
  int errors = 0;

  // Reference cycle count: zero in reset, +1 on every rdy_in-high edge.
  logic [31:0] cyc_model;

  ram_io_responder #(
    .RAM_ADDR_W  (17),
    .TX_DEPTH    (8),
    .FULL_MARGIN (2)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_pop         (rx_pop),
    .prog_done      (prog_done),
    .tx_overflow    (tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (rst_in)      cyc_model <= 32'd0;
    else if (rdy_in) cyc_model <= cyc_model + 32'd1;
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_wr(input logic [31:0] a, input logic [7:0] d);
    mem_a = a; mem_wr = 1'b1; mem_wdata = d;
  endtask

  task automatic set_rd(input logic [31:0] a);
    mem_a = a; mem_wr = 1'b0; mem_wdata = 8'h00;
  endtask

  task automatic set_idle();
    set_rd(32'h0003_0008);
  endtask

  task automatic do_reset();
    rst_in = 1'b1; rdy_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0;
    set_idle();
    tick(); tick();
    rst_in = 1'b0;
  endtask

  task automatic fill_tx8();
    for (int k = 0; k < 8; k++) begin
      set_wr(32'h0003_0000, 8'(8'h61 + k));
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    set_idle();
    tick(); tick();
    checks++; if (mem_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", mem_rdata); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid: got %b want 0", tx_valid); end
    checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", io_buffer_full); end
    checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL reset_rx_pop: got %b want 0", rx_pop); end
    checks++; if (prog_done !== 1'b0) begin errors++; $display("FAIL reset_prog_done: got %b want 0", prog_done); end
    checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", tx_overflow); end
    rst_in = 1'b0;
    // First edge out of reset sees counter 0, the next one sees 1.
    set_rd(32'h0003_0004); tick();
    checks++; if (mem_rdata !== 8'h00) begin errors++; $display("FAIL cnt_start0: got %h want 00", mem_rdata); end
    set_rd(32'h0003_0004); tick();
    checks++; if (mem_rdata !== 8'h01) begin errors++; $display("FAIL cnt_start1: got %h want 01", mem_rdata); end
  endtask

  task automatic test_ram();
    set_wr(32'h0000_0010, 8'hA5); tick();
    set_rd(32'h0000_0010); tick();
    checks++; if (mem_rdata !== 8'hA5) begin errors++; $display("FAIL ram_raw: got %h want a5", mem_rdata); end
    set_wr(32'h0001_FFFF, 8'h3C); tick();
    set_wr(32'h0000_FFFF, 8'hC3); tick();
    set_wr(32'h0000_0011, 8'h11); tick();
    set_rd(32'h0001_FFFF); tick();
    checks++; if (mem_rdata !== 8'h3C) begin errors++; $display("FAIL ram_top: got %h want 3c", mem_rdata); end
    set_rd(32'h0000_FFFF); tick();
    checks++; if (mem_rdata !== 8'hC3) begin errors++; $display("FAIL ram_ffff: got %h want c3", mem_rdata); end
    set_rd(32'h0000_0011); tick();
    checks++; if (mem_rdata !== 8'h11) begin errors++; $display("FAIL ram_11: got %h want 11", mem_rdata); end
    set_rd(32'hFFFC_0010); tick();
    checks++; if (mem_rdata !== 8'hA5) begin errors++; $display("FAIL ram_hi_ignored: got %h want a5", mem_rdata); end
    set_wr(32'h0000_0011, 8'h5B); tick();
    set_rd(32'h0000_0011); tick();
    checks++; if (mem_rdata !== 8'h5B) begin errors++; $display("FAIL ram_overwrite: got %h want 5b", mem_rdata); end
  endtask

  task automatic test_rx();
    rx_valid = 1'b1; rx_data = 8'h41;
    set_rd(32'h0003_0000); #1;
    checks++; if (rx_pop !== 1'b1) begin errors++; $display("FAIL rx_pop_hi: got %b want 1", rx_pop); end
    tick();
    checks++; if (mem_rdata !== 8'h41) begin errors++; $display("FAIL rx_data: got %h want 41", mem_rdata); end
    rx_valid = 1'b0; #1;
    checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL rx_pop_empty: got %b want 0", rx_pop); end
    tick();
    checks++; if (mem_rdata !== 8'h00) begin errors++; $display("FAIL rx_empty_data: got %h want 00", mem_rdata); end
    rx_valid = 1'b1;
    set_rd(32'h0000_0010); #1;
    checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL rx_pop_ram: got %b want 0", rx_pop); end
    tick();
    checks++; if (mem_rdata !== 8'hA5) begin errors++; $display("FAIL rx_ram_data: got %h want a5", mem_rdata); end
    rx_valid = 1'b0;
  endtask

  task automatic test_counter();
    logic [7:0] exp_b1;
    do_reset();
    set_idle();
    for (int i = 0; i < 400 && cyc_model != 32'h0000_00FF; i++) tick();
    checks++;
    if (cyc_model !== 32'h0000_00FF) begin
      errors++; $display("FAIL cnt_wait: got %h want 000000ff", cyc_model);
    end
    set_rd(32'h0003_0004); tick();
    checks++; if (mem_rdata !== 8'hFF) begin errors++; $display("FAIL cnt_b0: got %h want ff", mem_rdata); end
`ifdef CYCLE_SNAPSHOT_EN
    exp_b1 = 8'h00;
`else
    exp_b1 = 8'h01;
`endif
    set_rd(32'h0003_0005); tick();
    checks++; if (mem_rdata !== exp_b1) begin errors++; $display("FAIL cnt_b1: got %h want %h", mem_rdata, exp_b1); end
    set_rd(32'h0003_0006); tick();
    checks++; if (mem_rdata !== 8'h00) begin errors++; $display("FAIL cnt_b2: got %h want 00", mem_rdata); end
    set_rd(32'h0003_0007); tick();
    checks++; if (mem_rdata !== 8'h00) begin errors++; $display("FAIL cnt_b3: got %h want 00", mem_rdata); end
    set_rd(32'h0003_0004); tick();  // counter now 0x103
    checks++; if (mem_rdata !== 8'h03) begin errors++; $display("FAIL cnt_b0_again: got %h want 03", mem_rdata); end
    set_rd(32'h0003_0010); tick();
    checks++; if (mem_rdata !== 8'h00) begin errors++; $display("FAIL io_unmapped: got %h want 00", mem_rdata); end
  endtask

  task automatic test_tx_fill();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      set_wr(32'h0003_0000, 8'(8'h61 + k)); tick();
      checks++;
      if (io_buffer_full !== (k >= 5)) begin
        errors++; $display("FAIL tx_full_push%0d: got %b want %b", k, io_buffer_full, (k >= 5));
      end
    end
    checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL tx_no_ovf: got %b want 0", tx_overflow); end
    set_wr(32'h0003_0000, 8'h69); tick();
    checks++; if (tx_overflow !== 1'b1) begin errors++; $display("FAIL tx_ovf: got %b want 1", tx_overflow); end
    set_idle(); tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h61 + k)) begin
        errors++; $display("FAIL tx_drain%0d: got v=%b %h want v=1 %h", k, tx_valid, tx_data, 8'(8'h61 + k));
      end
      tick();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_empty: got %b want 0", tx_valid); end
    checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL tx_full_clear: got %b want 0", io_buffer_full); end
    tx_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [8];
    do_reset();
    fill_tx8();
    tx_ready = 1'b1;
    set_wr(32'h0003_0000, 8'h7A); tick();
    checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL b2b_ovf: got %b want 0", tx_overflow); end
    checks++; if (io_buffer_full !== 1'b1) begin errors++; $display("FAIL b2b_full: got %b want 1", io_buffer_full); end
    for (int k = 0; k < 7; k++) exp[k] = 8'(8'h62 + k);
    exp[7] = 8'h7A;
    set_idle();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp[k]) begin
        errors++; $display("FAIL b2b_drain%0d: got v=%b %h want v=1 %h", k, tx_valid, tx_data, exp[k]);
      end
      tick();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_prog_done();
    do_reset();
    set_wr(32'h0003_0000, 8'h00); tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL pd_zero_filter: got %b want 0", tx_valid); end
    set_wr(32'h0003_0004, 8'h00); tick();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h00 || prog_done !== 1'b1) begin
      errors++; $display("FAIL pd_stop: got v=%b d=%h pd=%b want v=1 d=00 pd=1", tx_valid, tx_data, prog_done);
    end
    set_wr(32'h0003_0000, 8'h42); tick();
    set_wr(32'h0003_0004, 8'h00); tick();
    set_wr(32'h0000_0020, 8'h5A); tick();
    set_rd(32'h0000_0020); tick();
    checks++; if (mem_rdata !== 8'h5A) begin errors++; $display("FAIL pd_ram: got %h want 5a", mem_rdata); end
    set_idle(); tx_ready = 1'b1; tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL pd_ignored: got %b want 0", tx_valid); end
    checks++; if (prog_done !== 1'b1) begin errors++; $display("FAIL pd_sticky: got %b want 1", prog_done); end
    tx_ready = 1'b0;
  endtask

  task automatic test_rdy_hold();
    logic [31:0] v;
    do_reset();
    set_wr(32'h0003_0000, 8'h61); tick();
    set_wr(32'h0003_0000, 8'h62); tick();
    set_rd(32'h0000_0010); tick();
    checks++; if (mem_rdata !== 8'hA5) begin errors++; $display("FAIL rdy_pre: got %h want a5", mem_rdata); end
    v = cyc_model;
    rdy_in = 1'b0; tx_ready = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      if (i == 1)      set_rd(32'h0003_0000);
      else if (i >= 3) set_wr(32'h0000_0010, 8'h77);
      else             set_wr(32'h0003_0000, 8'h63);
      #1;
      checks++; if (rx_pop !== 1'b0) begin errors++; $display("FAIL rdy_rx_pop%0d: got %b want 0", i, rx_pop); end
      tick();
      checks++;
      if (mem_rdata !== 8'hA5 || tx_valid !== 1'b1 || tx_data !== 8'h61) begin
        errors++; $display("FAIL rdy_hold%0d: got rd=%h v=%b d=%h want rd=a5 v=1 d=61", i, mem_rdata, tx_valid, tx_data);
      end
    end
    rdy_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0;
    set_rd(32'h0003_0004); tick();
    checks++; if (mem_rdata !== v[7:0]) begin errors++; $display("FAIL rdy_cnt: got %h want %h", mem_rdata, v[7:0]); end
    set_rd(32'h0000_0010); tick();
    checks++; if (mem_rdata !== 8'hA5) begin errors++; $display("FAIL rdy_ram_nowrite: got %h want a5", mem_rdata); end
    set_idle(); tx_ready = 1'b1;
    checks++; if (tx_data !== 8'h61) begin errors++; $display("FAIL rdy_drain0: got %h want 61", tx_data); end
    tick();
    checks++; if (tx_data !== 8'h62 || tx_valid !== 1'b1) begin errors++; $display("FAIL rdy_drain1: got v=%b %h want v=1 62", tx_valid, tx_data); end
    tick();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rdy_drain_end: got %b want 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_reset_full();
    do_reset();
    fill_tx8();
    set_wr(32'h0003_0004, 8'h00); tick();
    checks++;
    if (tx_overflow !== 1'b1 || prog_done !== 1'b1 || io_buffer_full !== 1'b1) begin
      errors++; $display("FAIL rf_pre: got ovf=%b pd=%b full=%b want 1 1 1", tx_overflow, prog_done, io_buffer_full);
    end
    set_rd(32'h0000_0010); tick();
    checks++; if (mem_rdata !== 8'hA5) begin errors++; $display("FAIL rf_rdata_pre: got %h want a5", mem_rdata); end
    rst_in = 1'b1; tick();
    checks++;
    if (mem_rdata !== 8'h00 || tx_valid !== 1'b0 || io_buffer_full !== 1'b0 ||
        prog_done !== 1'b0 || tx_overflow !== 1'b0) begin
      errors++; $display("FAIL rf_reset: got rd=%h v=%b full=%b pd=%b ovf=%b want all 0",
                         mem_rdata, tx_valid, io_buffer_full, prog_done, tx_overflow);
    end
    rst_in = 1'b0;
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; tx_ready = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00;
    mem_a = 32'h0003_0008; mem_wr = 1'b0; mem_wdata = 8'h00;
    test_reset();
    test_ram();
    test_rx();
    test_counter();
    test_tx_fill();
    test_back_to_back();
    test_prog_done();
    test_rdy_hold();
    test_reset_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
